gp_chain_serial: RTL and testbench

- Bit-serial evaluator for a generate/propagate carry chain: c[i] = g[i] | (p[i] & c[i-1]), seeded by c[-1] = seed.
- Evaluates one stage per cycle, replacing a long combinational AND-OR ripple.
- Sits downstream of the g/p formation stage and feeds the tap consumers.
- Valid/ready handshake on both sides; one transaction in flight.

---
 rtl/gp_chain_serial_pkg.sv | 18 +
 rtl/gp_chain_serial_if.sv | 38 +++
 rtl/gp_chain_cell.sv | 31 +++
 rtl/gp_chain_serial.sv | 105 ++++++++++
 tb/tb_gp_chain_serial.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/gp_chain_serial_pkg.sv
// Shared types and helpers for the bit-serial generate/propagate chain.
// Optional statistics counter is enabled with GP_CHAIN_STATS_EN.
package gp_chain_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int STAT_W = 16;

    // One carry-chain stage: generate, or propagate the incoming carry.
    function automatic logic gp_step(input logic g, input logic p, input logic c);
        return g | (p & c);
    endfunction

endpackage

// File: rtl/gp_chain_serial_if.sv
// Request/response handshake bundle between the g/p formation stage, the chain and the tap consumers.
// stat_count is only present when GP_CHAIN_STATS_EN is defined.
interface gp_chain_serial_if
    import gp_chain_pkg::*;
#(
    parameter int STAGES = 5
);
    logic              in_valid;
    logic              in_ready;
    logic              seed;
    logic [STAGES-1:0] g;
    logic [STAGES-1:0] p;
    logic              out_valid;
    logic              out_ready;
    logic [STAGES-1:0] taps;
    logic              carry_out;
`ifdef GP_CHAIN_STATS_EN
    logic [STAT_W-1:0] stat_count;

    modport master (
        output in_valid, seed, g, p, out_ready,
        input  in_ready, out_valid, taps, carry_out, stat_count
    );
    modport slave (
        input  in_valid, seed, g, p, out_ready,
        output in_ready, out_valid, taps, carry_out, stat_count
    );
`else
    modport master (
        output in_valid, seed, g, p, out_ready,
        input  in_ready, out_valid, taps, carry_out
    );
    modport slave (
        input  in_valid, seed, g, p, out_ready,
        output in_ready, out_valid, taps, carry_out
    );
`endif
endinterface

// File: rtl/gp_chain_cell.sv
// Single registered chain stage: holds the running carry and flags when a tap should be written.
module gp_chain_cell
    import gp_chain_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic seed,
    input  logic step_en,
    input  logic g_bit,
    input  logic p_bit,
    output logic c_next,
    output logic tap_we
);
    logic acc;

    assign c_next = gp_step(g_bit, p_bit, acc);
    assign tap_we = step_en;

    // Accumulator starts at the seed and then walks the chain one stage per step.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc <= 1'b0;
        end else if (load) begin
            acc <= seed;
        end else if (step_en) begin
            acc <= c_next;
        end
    end

endmodule

// File: rtl/gp_chain_serial.sv
// Bit-serial generate/propagate carry chain evaluator, one stage per cycle.
// Define GP_CHAIN_STATS_EN to add the saturating completed-transaction counter.
module gp_chain_serial
    import gp_chain_pkg::*;
#(
    parameter int STAGES = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    gp_chain_serial_if.slave  bus
);
    localparam int IDX_W = (STAGES > 1) ? $clog2(STAGES) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(STAGES - 1);

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  idx_q;
    logic [STAGES-1:0] g_r, p_r, taps_q;
    logic              accept, step, c_next, tap_we;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        step    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    accept  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                if (idx_q == LAST) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    gp_chain_cell u_cell (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (accept),
        .seed    (bus.seed),
        .step_en (step),
        .g_bit   (g_r[idx_q]),
        .p_bit   (p_r[idx_q]),
        .c_next  (c_next),
        .tap_we  (tap_we)
    );

    // Operands are captured once so upstream may change g/p freely during the walk; idx holds at LAST.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx_q  <= '0;
            g_r    <= '0;
            p_r    <= '0;
            taps_q <= '0;
        end else if (accept) begin
            idx_q  <= '0;
            g_r    <= bus.g;
            p_r    <= bus.p;
            taps_q <= '0;
        end else if (tap_we) begin
            taps_q[idx_q] <= c_next;
            if (idx_q != LAST) begin
                idx_q <= idx_q + 1'b1;
            end
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.taps      = taps_q;
    assign bus.carry_out = taps_q[STAGES-1];

`ifdef GP_CHAIN_STATS_EN
    logic [STAT_W-1:0] stat_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stat_q <= '0;
        end else if ((state_q == DONE) && bus.out_ready && (stat_q != {STAT_W{1'b1}})) begin
            stat_q <= stat_q + 1'b1;
        end
    end

    assign bus.stat_count = stat_q;
`endif

endmodule

// File: tb/tb_gp_chain_serial.sv
// Directed, table-driven bench for gp_chain_serial with STAGES=5 plus handshake and reset corner cases.
module tb_gp_chain_serial;

    logic clk;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;
    int   lat;

    gp_chain_serial_if #(.STAGES(5)) bus ();

    gp_chain_serial #(.STAGES(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic       seed;
        logic [4:0] g;
        logic [4:0] p;
        logic [4:0] exp_taps;
        logic       exp_carry;
    } vec_t;

    vec_t vecs[6];

    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
        end
    endtask

    // Called at a negedge; returns edges from accept until out_valid is seen.
    task automatic applyStimulus(input logic s, input logic [4:0] gv, input logic [4:0] pv, output int edges);
        int guard = 0;
        while (!bus.in_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("in_ready_before_accept", 16'(bus.in_ready), 16'd1);
        bus.in_valid = 1'b1;
        bus.seed     = s;
        bus.g        = gv;
        bus.p        = pv;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.seed     = 1'($urandom);
        bus.g        = 5'($urandom);
        bus.p        = 5'($urandom);
        edges = 0;
        while (!bus.out_valid && edges < 20) begin
            @(posedge clk);
            @(negedge clk);
            edges++;
        end
    endtask

    task automatic finishTxn();
        bus.out_ready = 1'b1;
        checkOutput("in_ready_in_done", 16'(bus.in_ready), 16'd0);
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;
        checkOutput("out_valid_after_hs", 16'(bus.out_valid), 16'd0);
        checkOutput("in_ready_after_hs", 16'(bus.in_ready), 16'd1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecs[0] = '{"full_propagate", 1'b1, 5'b00000, 5'b11111, 5'b11111, 1'b1};
        vecs[1] = '{"mid_generate",   1'b0, 5'b00100, 5'b11011, 5'b11100, 1'b1};
        vecs[2] = '{"kill",           1'b1, 5'b00000, 5'b11101, 5'b00001, 1'b0};
        vecs[3] = '{"no_seed",        1'b0, 5'b00000, 5'b11111, 5'b00000, 1'b0};
        vecs[4] = '{"gen_prop_mix",   1'b0, 5'b10001, 5'b01110, 5'b11111, 1'b1};
        vecs[5] = '{"gen_only",       1'b0, 5'b01010, 5'b00000, 5'b01010, 1'b0};

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.seed      = 1'b0;
        bus.g         = '0;
        bus.p         = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("rst_in_ready", 16'(bus.in_ready), 16'd1);
        checkOutput("rst_out_valid", 16'(bus.out_valid), 16'd0);
        checkOutput("rst_taps", 16'(bus.taps), 16'd0);
        checkOutput("rst_carry", 16'(bus.carry_out), 16'd0);
`ifdef GP_CHAIN_STATS_EN
        checkOutput("rst_stat", bus.stat_count, 16'd0);
`endif
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            applyStimulus(vecs[i].seed, vecs[i].g, vecs[i].p, lat);
            checkOutput({vecs[i].name, "_latency"}, 16'(lat), 16'd5);
            checkOutput({vecs[i].name, "_taps"}, 16'(bus.taps), 16'(vecs[i].exp_taps));
            checkOutput({vecs[i].name, "_carry"}, 16'(bus.carry_out), 16'(vecs[i].exp_carry));
            finishTxn();
        end
`ifdef GP_CHAIN_STATS_EN
        checkOutput("stat_after_table", bus.stat_count, 16'd6);
`endif

        // Backpressure with a competing request held on the input side.
        applyStimulus(1'b1, 5'b00000, 5'b11111, lat);
        checkOutput("bp_latency", 16'(lat), 16'd5);
        bus.in_valid = 1'b1;
        bus.seed     = 1'b0;
        bus.g        = 5'b00100;
        bus.p        = 5'b11011;
        for (int c = 0; c < 7; c++) begin
            @(posedge clk);
            @(negedge clk);
            checkOutput("bp_out_valid", 16'(bus.out_valid), 16'd1);
            checkOutput("bp_taps", 16'(bus.taps), 16'b11111);
            checkOutput("bp_in_ready", 16'(bus.in_ready), 16'd0);
        end
        bus.out_ready = 1'b1;
        checkOutput("bp_in_ready_hs_cycle", 16'(bus.in_ready), 16'd0);
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;
        checkOutput("bp_idle_in_ready", 16'(bus.in_ready), 16'd1);
        checkOutput("bp_idle_out_valid", 16'(bus.out_valid), 16'd0);
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.g        = 5'b11111;
        bus.p        = 5'b00000;
        bus.seed     = 1'b1;
        checkOutput("bp_accepted", 16'(bus.in_ready), 16'd0);
        lat = 0;
        while (!bus.out_valid && lat < 20) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        checkOutput("bp_next_latency", 16'(lat), 16'd5);
        checkOutput("bp_next_taps", 16'(bus.taps), 16'b11100);
        finishTxn();

        // Reset in the middle of a walk abandons it.
        bus.in_valid = 1'b1;
        bus.seed     = 1'b1;
        bus.g        = 5'b00000;
        bus.p        = 5'b11111;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
        end
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        checkOutput("midrst_in_ready", 16'(bus.in_ready), 16'd1);
        checkOutput("midrst_out_valid", 16'(bus.out_valid), 16'd0);
        checkOutput("midrst_taps", 16'(bus.taps), 16'd0);
        checkOutput("midrst_carry", 16'(bus.carry_out), 16'd0);
`ifdef GP_CHAIN_STATS_EN
        checkOutput("midrst_stat", bus.stat_count, 16'd0);
`endif
        for (int c = 0; c < 6; c++) begin
            @(posedge clk);
            @(negedge clk);
            checkOutput("midrst_no_result", 16'(bus.out_valid), 16'd0);
        end
        applyStimulus(1'b0, 5'b10000, 5'b00000, lat);
        checkOutput("post_rst_latency", 16'(lat), 16'd5);
        checkOutput("post_rst_taps", 16'(bus.taps), 16'b10000);
        checkOutput("post_rst_carry", 16'(bus.carry_out), 16'd1);
        finishTxn();

`ifdef GP_CHAIN_STATS_EN
        checkOutput("stat_after_rst_txn", bus.stat_count, 16'd1);
        force dut.stat_q = 16'hFFFF;
        #1;
        release dut.stat_q;
        applyStimulus(1'b1, 5'b00000, 5'b11111, lat);
        finishTxn();
        checkOutput("stat_saturate", bus.stat_count, 16'hFFFF);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
